// File: rtl/fuzz_if.sv
// Operand and result bundle for fuzz_top.
// The stimulus side drives the four operand words and observes the packed result y.
interface fuzz_if;
    logic        [2:0]   wire0;
    logic signed [19:0]  wire1;
    logic signed [20:0]  wire2;
    logic        [21:0]  wire3;
    logic        [190:0] y;

    modport master (output wire0, output wire1, output wire2, output wire3, input y);
    modport slave  (input wire0, input wire1, input wire2, input wire3, output y);
endinterface

// File: rtl/fuzz_top.sv
// Two-stage arithmetic/bit-manipulation datapath packing eight fields and four flags into y.
// Stage 1 captures operands; stage 2 registers the packed result, an accumulator and a cycle count.
module fuzz_top (
    input logic   clk,
    input logic   rst_n,
    fuzz_if.slave bus
);

    logic        [2:0]   a0;
    logic signed [19:0]  a1;
    logic signed [20:0]  a2;
    logic        [21:0]  a3;
    logic        [21:0]  acc;
    logic        [31:0]  cnt;
    logic        [190:0] y;

    logic signed [40:0]  prod;
    logic signed [21:0]  sum;
    logic signed [20:0]  a1x;
    logic signed [20:0]  mx;
    logic        [21:0]  xr;
    logic        [21:0]  acc_d;
    logic        [4:0]   pop;
    logic        [43:0]  dbl;
    logic        [21:0]  rot;
    logic                lt;
    logic        [190:0] y_d;

    always_comb begin
        prod  = a1 * a2;
        sum   = a1 + a2;
        a1x   = a1;
        mx    = (a1x > a2) ? a1x : a2;
        xr    = a3 ^ {a1, a0[1:0]};
        acc_d = acc + a3;
        pop   = '0;
        for (int i = 0; i < 22; i++) begin
            pop = pop + 5'(a3[i]);
        end
        // Upper half of the doubled word shifted left is the 22-bit rotate.
        dbl   = {a3, a3} << a0;
        rot   = dbl[43:22];
        lt    = a1 < a2;
        y_d   = {prod, sum, xr, acc_d, cnt, mx, pop, rot, ^a1, ^a2, ^a3, lt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0  <= '0;
            a1  <= '0;
            a2  <= '0;
            a3  <= '0;
            acc <= '0;
            cnt <= '0;
            y   <= '0;
        end else begin
            a0  <= bus.wire0;
            a1  <= bus.wire1;
            a2  <= bus.wire2;
            a3  <= bus.wire3;
            acc <= acc_d;
            cnt <= cnt + 32'd1;
            y   <= y_d;
        end
    end

    assign bus.y = y;

endmodule

// File: tb/tb_fuzz_top.sv
// Random and directed stimulus for fuzz_top, checked against an arithmetic reference model.
module tb_fuzz_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fuzz_if bus ();

    fuzz_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Values driven on the operand wires, plus the model of captured state.
    int          d0, d1, d2;
    int unsigned d3;
    int          m_a0, m_a1, m_a2;
    int unsigned m_a3, m_acc, m_cnt;
    logic [190:0] m_y;

    task automatic check(input string tag, input logic [190:0] obs, input logic [190:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [190:0] model_y();
        longint       p;
        int           s, mx;
        int unsigned  xr, accn, rv;
        int           pc;
        logic [63:0]  pv;
        logic [31:0]  sv, mxv, xv, av, rvv, pcv;
        logic         p1, p2, p3, lt;
        p    = longint'(m_a1) * longint'(m_a2);
        s    = m_a1 + m_a2;
        mx   = (m_a1 > m_a2) ? m_a1 : m_a2;
        xr   = m_a3 ^ ((int'(m_a1 & 'hFFFFF) << 2) | (m_a0 & 3));
        accn = (m_acc + m_a3) % (1 << 22);
        pc   = 0;
        for (int i = 0; i < 22; i++) pc += (m_a3 >> i) & 1;
        rv   = ((m_a3 << m_a0) | (m_a3 >> (22 - m_a0))) & 'h3FFFFF;
        p1   = ($countones(m_a1 & 'hFFFFF) % 2) == 1;
        p2   = ($countones(m_a2 & 'h1FFFFF) % 2) == 1;
        p3   = ($countones(m_a3) % 2) == 1;
        lt   = m_a1 < m_a2;
        pv = p; sv = s; mxv = mx; xv = xr; av = accn; rvv = rv; pcv = pc;
        return {pv[40:0], sv[21:0], xv[21:0], av[21:0], m_cnt, mxv[20:0], pcv[4:0], rvv[21:0],
                p1, p2, p3, lt};
    endfunction

    task automatic model_reset();
        m_a0 = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0; m_acc = 0; m_cnt = 0; m_y = '0;
    endtask

    task automatic drive(input int w0, input int w1, input int w2, input int w3);
        d0 = w0 & 7; d1 = w1; d2 = w2; d3 = w3 & 'h3FFFFF;
        bus.wire0 = 3'(w0);
        bus.wire1 = 20'(w1);
        bus.wire2 = 21'(w2);
        bus.wire3 = 22'(w3);
    endtask

    task automatic drive_random();
        drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 'hFFFFF)) - 'h80000,
              int'($urandom_range(0, 'h1FFFFF)) - 'h100000, int'($urandom_range(0, 'h3FFFFF)));
    endtask

    // One rising edge: advance the model, then compare the whole word shortly after.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_y   = model_y();
            m_acc = (m_acc + m_a3) % (1 << 22);
            m_cnt = m_cnt + 1;
            m_a0 = d0; m_a1 = d1; m_a2 = d2; m_a3 = d3;
        end
        #2;
        check("y", bus.y, m_y);
    endtask

    // Asynchronous reset pulse between edges, then release before the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst", bus.y, 191'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        drive_random();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_held", bus.y, 191'd0);
            drive_random();
        end
        rst_n = 1'b1;

        // Arithmetic: 3 * -2
        drive(0, 3, -2, 0);
        tick(); tick();
        check("prod_3x-2", 191'(bus.y[190:150]), 191'(41'h1FFFFFFFFFA));
        check("sum_3+-2", 191'(bus.y[149:128]), 191'(22'h000001));
        check("max_3_-2", 191'(bus.y[51:31]), 191'(21'd3));
        check("lt_3_-2", 191'(bus.y[0]), 191'(1'b0));
        check("par_a1", 191'(bus.y[3]), 191'(1'b0));

        // Rotate, including wrap-around and rotate-by-zero.
        drive(5, 0, 0, 'h000001);
        tick(); tick();
        check("rot5", 191'(bus.y[25:4]), 191'(22'h000020));
        check("pop1", 191'(bus.y[30:26]), 191'(5'd1));
        drive(1, 0, 0, 'h200000);
        tick(); tick();
        check("rot_wrap", 191'(bus.y[25:4]), 191'(22'h000001));
        drive(0, 0, 0, 'h12345);
        tick(); tick();
        check("rot0", 191'(bus.y[25:4]), 191'(22'h012345));

        // Extremes: most-negative operands.
        drive(0, -524288, -1048576, 0);
        tick(); tick();
        check("prod_ext", 191'(bus.y[190:150]), 191'(41'h08000000000));
        check("sum_ext", 191'(bus.y[149:128]), 191'(22'h280000));
        check("lt_ext", 191'(bus.y[0]), 191'(1'b0));

        // Accumulator wrap and counter sequence from a fresh reset.
        pulse_reset();
        drive(0, 0, 0, 'h3FFFFF);
        tick();
        check("cnt0", 191'(bus.y[83:52]), 191'(32'd0));
        check("acc0", 191'(bus.y[105:84]), 191'(22'd0));
        tick();
        check("cnt1", 191'(bus.y[83:52]), 191'(32'd1));
        check("acc1", 191'(bus.y[105:84]), 191'(22'h3FFFFF));
        check("pop22", 191'(bus.y[30:26]), 191'(5'd22));
        tick();
        check("cnt2", 191'(bus.y[83:52]), 191'(32'd2));
        check("acc2", 191'(bus.y[105:84]), 191'(22'h3FFFFE));
        tick();
        check("acc3", 191'(bus.y[105:84]), 191'(22'h3FFFFD));

        // Counter wrap via a preload.
        force dut.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cnt;
        m_cnt = 32'hFFFF_FFFF;
        tick();
        check("cnt_max", 191'(bus.y[83:52]), 191'(32'hFFFF_FFFF));
        tick();
        check("cnt_wrap", 191'(bus.y[83:52]), 191'(32'd0));

        // Random run with occasional mid-stream resets.
        for (int i = 0; i < 300; i++) begin
            drive_random();
            if ($urandom_range(0, 63) == 0) pulse_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
